// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizes for the multiport register file.
//   rf_state_t    - controller state (sweep clear / normal operation)
//   RF_DATA_WIDTH - default register width
//   RF_ADDR_WIDTH - default address width (DEPTH = 2**RF_ADDR_WIDTH)
package regfile_pkg;
  typedef enum logic {RF_CLEAR = 1'b0, RF_IDLE = 1'b1} rf_state_t;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one registered read port of the register file.
//   clock, reset   - rising-edge clock, synchronous active-low reset
//   sweeping       - clear sweep in progress; forces output to zero
//   addr           - read address for this port
//   wr_en          - write that will actually commit this cycle
//   wr_addr/wr_data- that write, used for write-first bypass
//   mem_data       - array contents at addr
//   data           - registered read data
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sweeping,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] data
);
  always_ff @(posedge clock) begin
    if (!reset)
      data <= '0;
    else if (sweeping)
      data <= '0;
    else if (ZERO_REG != 0 && addr == '0)
      data <= '0;
    else if (wr_en && wr_addr == addr)
      data <= wr_data;   // write-first bypass
    else
      data <= mem_data;
  end
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: parameterised register file, READ_PORTS registered read
// ports with write-first bypass, one write port, and a sequential clear
// sweep (one entry per cycle) after reset or on request.
//   clock, reset   - rising-edge clock, synchronous active-low reset
//   we, rd         - write enable / write address
//   input_data     - write data
//   rs             - packed read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   clear          - request a full clear sweep (ignored while sweeping)
//   output_data    - packed read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   busy           - clear sweep in progress
//   write_dropped  - pulse: a write was discarded during the sweep
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             we,
  input  logic [ADDR_WIDTH-1:0]            rd,
  input  logic [DATA_WIDTH-1:0]            input_data,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] rs,
  input  logic                             clear,
  output logic [READ_PORTS*DATA_WIDTH-1:0] output_data,
  output logic                             busy,
  output logic                             write_dropped
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  rf_state_t             state;
  logic [ADDR_WIDTH-1:0] sweep_ptr;
  logic                  wr_ok;

  // No reset on the array: the sweep zeroes it, keeping it RAM-inferable.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign wr_ok = (state == RF_IDLE) && we && !(ZERO_REG != 0 && rd == '0);
  assign busy  = (state == RF_CLEAR);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= RF_CLEAR;
      sweep_ptr     <= '0;
      write_dropped <= 1'b0;
    end else begin
      write_dropped <= (state == RF_CLEAR) && we;
      case (state)
        RF_CLEAR: begin
          // pointer wraps to 0 on the last entry, ready for the next sweep
          sweep_ptr <= sweep_ptr + 1'b1;
          if (sweep_ptr == '1) state <= RF_IDLE;
        end
        RF_IDLE: begin
          if (clear) begin
            state     <= RF_CLEAR;
            sweep_ptr <= '0;
          end
        end
        default: state <= RF_CLEAR;
      endcase
    end
  end

  // Sweep and write are mutually exclusive by state; nothing commits in reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (state == RF_CLEAR)
        mem[sweep_ptr] <= '0;
      else if (wr_ok)
        mem[rd] <= input_data;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
    ) u_port (
      .clock    (clock),
      .reset    (reset),
      .sweeping (state == RF_CLEAR),
      .addr     (rs[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .wr_en    (wr_ok),
      .wr_addr  (rd),
      .wr_data  (input_data),
      .mem_data (mem[rs[p*ADDR_WIDTH +: ADDR_WIDTH]]),
      .data     (output_data[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: three instances (default, ZERO_REG=0, and a
// 4-port 16-bit 8-entry variant) checked every cycle against a countdown /
// array reference model, plus directed constant checks.
module tb_regfile_multiport;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  // instances A (ZERO_REG=1) and B (ZERO_REG=0) share stimulus
  logic        reset_ab, we_ab, clr_ab;
  logic [4:0]  rd_ab;
  logic [31:0] din_ab;
  logic [9:0]  rs_ab;
  logic [63:0] od_a, od_b;
  logic        busy_a, busy_b, wd_a, wd_b;

  // instance C: 4 ports, 16-bit, 8 entries
  logic        reset_c, we_c, clr_c;
  logic [2:0]  rd_c;
  logic [15:0] din_c;
  logic [11:0] rs_c;
  logic [63:0] od_c;
  logic        busy_c, wd_c;

  regfile_multiport u_a (
    .clock(clock), .reset(reset_ab), .we(we_ab), .rd(rd_ab), .input_data(din_ab),
    .rs(rs_ab), .clear(clr_ab), .output_data(od_a), .busy(busy_a), .write_dropped(wd_a));

  regfile_multiport #(.ZERO_REG(0)) u_b (
    .clock(clock), .reset(reset_ab), .we(we_ab), .rd(rd_ab), .input_data(din_ab),
    .rs(rs_ab), .clear(clr_ab), .output_data(od_b), .busy(busy_b), .write_dropped(wd_b));

  regfile_multiport #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .READ_PORTS(4)) u_c (
    .clock(clock), .reset(reset_c), .we(we_c), .rd(rd_c), .input_data(din_c),
    .rs(rs_c), .clear(clr_c), .output_data(od_c), .busy(busy_c), .write_dropped(wd_c));

  int checks   = 0;
  int failures = 0;

  // reference model: contents, remaining sweep edges, expected outputs
  logic [31:0] mem_m [3][32];
  int          rem   [3];
  logic [31:0] exp_o [3][4];
  logic        exp_wd[3];
  int          prs   [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input int k, input int depth, input bit zr, input int np,
                       input bit rst, input bit w, input int a, input logic [31:0] d,
                       input bit c);
    bit wq;
    if (!rst) begin
      rem[k] = depth;
      for (int p = 0; p < 4; p++) exp_o[k][p] = '0;
      exp_wd[k] = 1'b0;
    end else if (rem[k] > 0) begin
      mem_m[k][depth - rem[k]] = '0;
      rem[k] = rem[k] - 1;
      for (int p = 0; p < 4; p++) exp_o[k][p] = '0;
      exp_wd[k] = w;
    end else begin
      wq = w && !(zr && a == 0);
      for (int p = 0; p < 4; p++) begin
        if (p >= np)                 exp_o[k][p] = '0;
        else if (zr && prs[p] == 0)  exp_o[k][p] = '0;
        else if (wq && a == prs[p])  exp_o[k][p] = d;
        else                         exp_o[k][p] = mem_m[k][prs[p]];
      end
      if (wq) mem_m[k][a] = d;
      if (c) rem[k] = depth;
      exp_wd[k] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    prs[0] = int'(rs_ab[4:0]);
    prs[1] = int'(rs_ab[9:5]);
    prs[2] = 0;
    prs[3] = 0;
    model(0, 32, 1'b1, 2, reset_ab, we_ab, int'(rd_ab), din_ab, clr_ab);
    model(1, 32, 1'b0, 2, reset_ab, we_ab, int'(rd_ab), din_ab, clr_ab);
    for (int p = 0; p < 4; p++) prs[p] = int'(rs_c[p*3 +: 3]);
    model(2, 8, 1'b1, 4, reset_c, we_c, int'(rd_c), {16'h0, din_c}, clr_c);
    #1;
    for (int p = 0; p < 2; p++) begin
      check("a_out", od_a[p*32 +: 32], exp_o[0][p]);
      check("b_out", od_b[p*32 +: 32], exp_o[1][p]);
    end
    for (int p = 0; p < 4; p++)
      check("c_out", {16'h0, od_c[p*16 +: 16]}, exp_o[2][p]);
    check("a_busy", 32'(busy_a), 32'(rem[0] > 0));
    check("b_busy", 32'(busy_b), 32'(rem[1] > 0));
    check("c_busy", 32'(busy_c), 32'(rem[2] > 0));
    check("a_drop", 32'(wd_a), 32'(exp_wd[0]));
    check("b_drop", 32'(wd_b), 32'(exp_wd[1]));
    check("c_drop", 32'(wd_c), 32'(exp_wd[2]));
  endtask

  task automatic rand_ab(input int we_pct);
    we_ab  = ($urandom_range(0, 99) < we_pct);
    rd_ab  = 5'($urandom_range(0, 31));
    din_ab = $urandom;
    rs_ab  = 10'($urandom);
    clr_ab = 1'b0;
  endtask

  task automatic rand_c(input int we_pct);
    we_c  = ($urandom_range(0, 99) < we_pct);
    rd_c  = 3'($urandom_range(0, 7));
    din_c = 16'($urandom);
    rs_c  = 12'($urandom);
    clr_c = 1'b0;
  endtask

  initial begin
    int cnt_a, cnt_c;
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0;
      exp_wd[k] = 1'b0;
      for (int i = 0; i < 32; i++) mem_m[k][i] = '0;
      for (int p = 0; p < 4; p++) exp_o[k][p] = '0;
    end
    reset_ab = 1'b0; reset_c = 1'b0;
    rand_ab(50); rand_c(50);
    step();
    step();

    // release; C gets a reset mid-sweep that must restart its 8-edge count
    reset_ab = 1'b1; reset_c = 1'b1;
    cnt_a = 0; cnt_c = 0;
    for (int i = 0; i < 40; i++) begin
      rand_ab(30); rand_c(30);
      reset_c = (i != 4);
      if (busy_a) cnt_a++;
      if (i > 4 && busy_c) cnt_c++;
      step();
    end
    reset_c = 1'b1;
    check("busy_len_a", cnt_a, 32);
    check("busy_len_c", cnt_c, 8);

    // bypass on port 0, then plain read on port 1
    we_ab = 1'b1; rd_ab = 5'd5; din_ab = 32'hDEADBEEF; rs_ab = {5'd0, 5'd5};
    we_c = 1'b0;
    step();
    check("bypass_p0", od_a[31:0], 32'hDEADBEEF);
    we_ab = 1'b0; rs_ab = {5'd5, 5'd0};
    step();
    check("read_p1", od_a[63:32], 32'hDEADBEEF);

    // entry 0 write: hard-wired zero in A, real storage in B
    we_ab = 1'b1; rd_ab = 5'd0; din_ab = 32'h12345678; rs_ab = '0;
    step();
    we_ab = 1'b0;
    step();
    check("zero_a", od_a[31:0], 32'h0);
    check("zero_b", od_b[31:0], 32'h12345678);

    // C: four distinct addresses read together
    for (int a = 1; a <= 4; a++) begin
      we_c = 1'b1; rd_c = 3'(a); din_c = 16'hA000 + 16'(a);
      step();
    end
    we_c = 1'b0; rs_c = {3'd4, 3'd3, 3'd2, 3'd1};
    step();
    for (int p = 0; p < 4; p++)
      check("c_four", {16'h0, od_c[p*16 +: 16]}, 32'hA001 + 32'(p));

    // fill A/B, then clear with a second ignored request mid-sweep
    for (int i = 0; i < 40; i++) begin
      rand_ab(100);
      if (din_ab == 0) din_ab = 32'h1;
      step();
    end
    cnt_a = 0;
    for (int j = 0; j < 40; j++) begin
      rand_ab(j < 32 ? 20 : 0);
      clr_ab = (j == 0 || j == 10);
      step();
      if (busy_a) cnt_a++;
    end
    clr_ab = 1'b0;
    check("clear_len", cnt_a, 32);
    we_ab = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs_ab = {5'(a), 5'(a)};
      step();
      check("cleared_a", od_a[31:0], 32'h0);
      check("cleared_b", od_b[63:32], 32'h0);
    end

    // random mix with occasional clears
    for (int i = 0; i < 300; i++) begin
      rand_ab(40); rand_c(40);
      clr_ab = ($urandom_range(0, 49) == 0);
      clr_c  = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
